reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
Parametrised multi-read-port register file for the single-cycle MIPS datapath. It succeeds the fixed 32x32, 2-read, 1-write register file. It adds configurable width, depth and read-port count, a hardwired zero register, and a sequential post-reset clear engine so contents are defined without initial blocks. An optional write-to-read bypass is also available. It sits between instruction decode (register operands) and ALU/memory writeback.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous active-high reset
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W]
rw_reg  input  ADDR_W  write address
reg_write  input  1  write enable
wr_data  input  DATA_W  write data
o_busy  output  1  high while the clear engine runs; writes are ignored
o_wr_drop  output  1  registered; pulses 1 cycle when a reg_write was ignored (busy, or address 0 with ZERO_REG=1)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is i_clk, reset port is i_rst.
- Storage: DEPTH x DATA_W array.
- Reads are combinational (asynchronous) from the array; zero-cycle latency.
- Writes take effect at the rising edge; visible on rd_data the cycle after.
- Clear engine FSM, states CLEAR and READY:
  - i_rst=1 at an edge: state <= CLEAR, clr_ptr <= 0, o_busy <= 1, o_wr_drop <= 0.
  - CLEAR: each cycle mem[clr_ptr] <= 0 and clr_ptr <= clr_ptr+1. In the cycle with clr_ptr == DEPTH-1, state <= READY and o_busy <= 0.
  - Clear takes exactly DEPTH cycles after the first non-reset edge; o_busy is high for those DEPTH cycles.
  - clr_ptr is ADDR_W bits wide, with no wrap beyond DEPTH-1.
  - READY: normal operation. Stays READY until i_rst.
  - i_rst asserted mid-clear: restart at clr_ptr=0, full DEPTH cycles again.
- While o_busy=1: all rd_data ports return 0 regardless of address. reg_write is ignored and o_wr_drop pulses the next cycle.
- ZERO_REG=1: a read of address 0 returns 0 always. A write to address 0 is discarded and o_wr_drop pulses.
- Multiple read ports may address the same register; all return the same value.
- o_wr_drop reset value 0. Otherwise o_wr_drop <= reg_write & (o_busy | (ZERO_REG & rw_reg==0)).
- Reset values: o_busy=1 (from the first edge with i_rst=1), o_wr_drop=0, rd_data=0 (busy forces zero).
- Array contents during reset cycles are unspecified until cleared.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: combinational write-to-read forwarding. If reg_write=1, o_busy=0, and rd_addr port k == rw_reg (and not address 0 when ZERO_REG=1), rd_data port k = wr_data in the same cycle.
- Not defined: same-cycle read of a register being written returns the old array value; the new value appears the next cycle.
- Either way, the array update is identical.

Test Plan:
1. Reset for 2 cycles then release. Required: o_busy high for exactly 32 cycles (default params). Reads of every address during busy = 0. Reads after o_busy falls = 0 for all 32 registers.
2. After ready, write 0xDEADBEEF to r7, then read r7 on ports 0 and 1 the next cycle. Required: both = 0xDEADBEEF, o_wr_drop = 0.
3. Write 0x12345678 to r0 with ZERO_REG=1. Required: o_wr_drop = 1 the next cycle only; reads of r0 = 0.
4. Write 0x5 to r3 while reading r3 in the same cycle. Required: rd_data = 0x5 with REGFILE_BYPASS_EN defined; rd_data = previous value (0 after clear) without it. r3 = 0x5 the next cycle in both builds.
5. Write 0xAA to r9, then assert i_rst for 1 cycle at clear count 10 of a second clear. Required: o_busy remains high 32 more cycles from restart. r9 reads 0 after completion. A reg_write issued during busy gives o_wr_drop = 1 and no array change.
6. NUM_RD=4, ADDR_W=3: write distinct values 1..7 to r1..r7, then drive the four ports with addresses 1, 7, 7, 0. Required: rd_data = 1, 7, 7, 0. Clear lasts 8 cycles.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file with post-reset clear engine.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
`default_nettype none

//------------------------------------------------------------------------------
// Module  : reg_file_mp
// Brief   : DEPTH x DATA_W register file, NUM_RD async read ports, 1 write port,
//           optional hardwired zero register, sequential clear after reset.
//           Build option: REGFILE_BYPASS_EN (write-to-read bypass).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic [ADDR_W-1:0]          rw_reg,
  input  logic                       reg_write,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       o_busy,
  output logic                       o_wr_drop
);

  localparam int                 DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic                busy_q, busy_d;
  logic                wr_drop_q, wr_drop_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                wr_zero_hit;

  assign wr_zero_hit = (ZERO_REG != 0) && (rw_reg == '0);

  // The clear engine and the user write port share the single array write port.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    wr_drop_d = reg_write & (busy_q | wr_zero_hit);
    mem_we    = 1'b0;
    mem_waddr = rw_reg;
    mem_wdata = wr_data;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        if (clr_ptr_q == LAST_IDX) begin
          state_d = READY;
          busy_d  = 1'b0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      READY: begin
        mem_we = reg_write & ~wr_zero_hit;
      end
      default: begin
        state_d = CLEAR;
        busy_d  = 1'b1;
      end
    endcase
    if (i_rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] port_addr;
      logic [DATA_W-1:0] port_data;

      assign port_addr = rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
        port_data = mem_q[port_addr];
`ifdef REGFILE_BYPASS_EN
        if (reg_write && !busy_q && (port_addr == rw_reg)) begin
          port_data = wr_data;
        end
`endif
        if (busy_q || ((ZERO_REG != 0) && (port_addr == '0))) begin
          port_data = '0;
        end
      end

      assign rd_data[k*DATA_W +: DATA_W] = port_data;
    end
  endgenerate

  assign o_busy    = busy_q;
  assign o_wr_drop = wr_drop_q;

endmodule

`default_nettype wire
